// File: rtl/coprocessor_pkg.sv
// Shared coprocessor definitions: operand types, walk modes,
// sequencer states and config field positions.
package coprocessor_pkg;

  localparam logic [2:0] TYPE_A = 3'b001;
  localparam logic [2:0] TYPE_B = 3'b010;
  localparam logic [2:0] TYPE_C = 3'b100;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_ROW    = 2'b01;
  localparam logic [1:0] MODE_COL    = 2'b10;

  localparam int CFG_LAMBDA_LSB = 0;
  localparam int CFG_GAMMA_LSB  = 8;
  localparam int CFG_MU_LSB     = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_EMIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/block_base_calc.sv
// Bounds check plus block base, walk stride and block count
// for one sequencer command.
module block_base_calc
  import coprocessor_pkg::*;
#(
  parameter int IW           = 8,
  parameter int K            = 2,
  parameter int W            = 20,
  parameter int INPUT_START  = 2,
  parameter int OUTPUT_START = 700
) (
  input  logic [IW-1:0] lambda,
  input  logic [IW-1:0] mu,
  input  logic [IW-1:0] gamma,
  input  logic [2:0]    typ,
  input  logic [1:0]    mode,
  input  logic [IW-1:0] row,
  input  logic [IW-1:0] col,
  output logic          err,
  output logic [W-1:0]  base,
  output logic [W-1:0]  step,
  output logic [IW-1:0] blocks
);

  localparam logic [W-1:0] KSQ = W'(K * K);

  logic          is_a, is_b, is_c;
  logic [IW-1:0] rows, cols;
  logic [W-1:0]  blk, origin;

  always_comb begin
    is_a   = (typ == TYPE_A);
    is_b   = (typ == TYPE_B);
    is_c   = (typ == TYPE_C);
    rows   = '0;
    cols   = '0;
    blk    = '0;
    origin = '0;
    unique case (1'b1)
      is_a: begin
        rows   = lambda;
        cols   = mu;
        blk    = W'(row) * W'(mu) + W'(col);
        origin = W'(INPUT_START);
      end
      is_b: begin
        rows   = mu;
        cols   = gamma;
        blk    = W'(lambda) * W'(mu)
               + W'(row) * W'(gamma) + W'(col);
        origin = W'(INPUT_START);
      end
      is_c: begin
        rows   = lambda;
        cols   = gamma;
        blk    = W'(row) * W'(gamma) + W'(col);
        origin = W'(OUTPUT_START);
      end
      default: ;
    endcase
  end

  always_comb begin
    base   = origin + blk * KSQ;
    // a column step skips one full block-row
    step   = (mode == MODE_COL) ? W'(cols) * KSQ : KSQ;
    blocks = '0;
    case (mode)
      MODE_SINGLE: blocks = IW'(1);
      MODE_ROW:    blocks = cols - col;
      MODE_COL:    blocks = rows - row;
      default:     blocks = '0;
    endcase
    err = !(is_a || is_b || is_c)
       || (mode == 2'b11)
       || (rows == '0) || (cols == '0)
       || (row >= rows) || (col >= cols);
  end

endmodule

// File: rtl/block_address_sequencer.sv
// Handshaked line-address stream over one block, block-row
// or block-column of the partitioned matrix memory.
module block_address_sequencer
  import coprocessor_pkg::*;
#(
  parameter int INDEX_WIDTH  = 8,
  parameter int K            = 2,
  parameter int ADDR_WIDTH   = 10,
  parameter int INPUT_START  = 2,
  parameter int OUTPUT_START = 700,
  localparam int PW = (K > 1) ? $clog2(K) : 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [31:0]            i_Config,
  input  logic                   i_Start,
  input  logic [2:0]             i_Type,
  input  logic [1:0]             i_Mode,
  input  logic [INDEX_WIDTH-1:0] i_Row_Index,
  input  logic [INDEX_WIDTH-1:0] i_Column_Index,
  input  logic                   i_Ready,
  output logic                   o_Valid,
  output logic [ADDR_WIDTH-1:0]  o_Address,
  output logic [PW-1:0]          o_Position,
  output logic [INDEX_WIDTH-1:0] o_Row_Index,
  output logic [INDEX_WIDTH-1:0] o_Column_Index,
  output logic                   o_Last,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Error
);

  localparam int IW = INDEX_WIDTH;
  localparam int W  = 2 * IW + 2 * $clog2(K) + 2;
  localparam logic [PW-1:0] POS_MAX = PW'(K - 1);
  localparam logic [W-1:0]  LINE    = W'(K);

  state_t        state, state_nx;
  logic [IW-1:0] lambda_q, mu_q, gamma_q;
  logic [IW-1:0] row_q, col_q, blocks_q;
  logic [2:0]    type_q;
  logic [1:0]    mode_q;
  logic [W-1:0]  base_q, addr_q, step_q;
  logic [PW-1:0] pos_q;
  logic          err_q;

  logic          c_err;
  logic [W-1:0]  c_base, c_step;
  logic [IW-1:0] c_blocks;
  logic          valid, fire, wrap, last;
  logic          unused_cfg;

  assign unused_cfg = ^i_Config;

  block_base_calc #(
    .IW           (IW),
    .K            (K),
    .W            (W),
    .INPUT_START  (INPUT_START),
    .OUTPUT_START (OUTPUT_START)
  ) u_calc (
    .lambda (lambda_q),
    .mu     (mu_q),
    .gamma  (gamma_q),
    .typ    (type_q),
    .mode   (mode_q),
    .row    (row_q),
    .col    (col_q),
    .err    (c_err),
    .base   (c_base),
    .step   (c_step),
    .blocks (c_blocks)
  );

  assign valid = (state == S_EMIT);
  assign fire  = valid && i_Ready;
  assign wrap  = (pos_q == POS_MAX);
  assign last  = wrap && (blocks_q == IW'(1));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (i_Start) state_nx = S_SETUP;
      S_SETUP: state_nx = c_err ? S_IDLE : S_EMIT;
      S_EMIT:  if (fire && last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      lambda_q <= '0;
      mu_q     <= '0;
      gamma_q  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      blocks_q <= '0;
      type_q   <= '0;
      mode_q   <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      step_q   <= '0;
      pos_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state == S_SETUP) && c_err;
      if (state == S_IDLE && i_Start) begin
        lambda_q <= i_Config[CFG_LAMBDA_LSB +: IW];
        gamma_q  <= i_Config[CFG_GAMMA_LSB +: IW];
        mu_q     <= i_Config[CFG_MU_LSB +: IW];
        type_q   <= i_Type;
        mode_q   <= i_Mode;
        row_q    <= i_Row_Index;
        col_q    <= i_Column_Index;
      end
      if (state == S_SETUP) begin
        base_q   <= c_base;
        addr_q   <= c_base;
        step_q   <= c_step;
        blocks_q <= c_blocks;
        pos_q    <= '0;
      end
      // incremental stepping replaces per-beat multiplies
      if (fire) begin
        if (wrap) begin
          pos_q    <= '0;
          base_q   <= base_q + step_q;
          addr_q   <= base_q + step_q;
          blocks_q <= blocks_q - IW'(1);
          if (mode_q == MODE_ROW) col_q <= col_q + IW'(1);
          if (mode_q == MODE_COL) row_q <= row_q + IW'(1);
        end else begin
          pos_q  <= pos_q + PW'(1);
          addr_q <= addr_q + LINE;
        end
      end
    end
  end

  assign o_Valid        = valid;
  assign o_Address      = valid ? ADDR_WIDTH'(addr_q) : '0;
  assign o_Position     = valid ? pos_q : '0;
  assign o_Row_Index    = valid ? row_q : '0;
  assign o_Column_Index = valid ? col_q : '0;
  assign o_Last         = valid && last;
  assign o_Busy         = (state != S_IDLE);
  assign o_Done         = (state == S_DONE);
  assign o_Error        = err_q;

endmodule
